// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, zero-register constant and address helpers for the register file
package regfile_pkg;

  localparam int unsigned XLEN_DEFAULT     = 64;
  localparam int unsigned NUM_REGS_DEFAULT = 32;
  localparam int unsigned NUM_READ_DEFAULT = 2;
  localparam int unsigned ADDR_W_DEFAULT   = $clog2(NUM_REGS_DEFAULT);
  localparam int unsigned ZERO_REG         = 0;

  typedef logic [ADDR_W_DEFAULT-1:0] reg_addr_t;

  // Writes, issues and reads all treat the hardwired zero register as inert.
  function automatic logic is_live_reg(input logic [31:0] addr);
    return addr != ZERO_REG;
  endfunction

endpackage

// File: rtl/multiport_register_file_scoreboard.sv
// rtl/multiport_register_file_scoreboard.sv - pending-write busy bits with issue-over-writeback priority
module regfile_scoreboard #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear_en,
  input  logic [ADDR_W-1:0]   clear_addr,
  input  logic                set_en,
  input  logic [ADDR_W-1:0]   set_addr,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_next;

  // Set is applied after clear so a same-cycle issue leaves the new producer outstanding.
  always_comb begin
    busy_next = busy;
    if (clear_en) busy_next[clear_addr] = 1'b0;
    if (set_en)   busy_next[set_addr]   = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

endmodule

// File: rtl/multiport_register_file.sv
// rtl/multiport_register_file.sv - multi-read-port register file with scoreboard; optional REGFILE_BYPASS_EN write-to-read bypass
module multiport_register_file
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEFAULT,
  parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT,
  parameter int unsigned NUM_READ = NUM_READ_DEFAULT,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       reg_write,
  input  logic [ADDR_W-1:0]          rd_address,
  input  logic [XLEN-1:0]            write_data,
  input  logic [NUM_READ*ADDR_W-1:0] rs_address,
  output logic [NUM_READ*XLEN-1:0]   rs_data,
  output logic [NUM_READ-1:0]        rs_busy,
  input  logic                       issue_valid,
  input  logic [ADDR_W-1:0]          issue_rd,
  output logic [NUM_REGS-1:0]        busy_vector
);

  logic [XLEN-1:0] regs [NUM_REGS];
  logic            wr_en;
  logic            iss_en;

  assign wr_en  = reg_write   && !reset && is_live_reg(32'(rd_address));
  assign iss_en = issue_valid && !reset && is_live_reg(32'(issue_rd));

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int n = 0; n < NUM_REGS; n++) regs[n] <= '0;
    end else if (wr_en) begin
      regs[rd_address] <= write_data;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clock      (clock),
    .reset      (reset),
    .clear_en   (wr_en),
    .clear_addr (rd_address),
    .set_en     (iss_en),
    .set_addr   (issue_rd),
    .busy       (busy_vector)
  );

  for (genvar i = 0; i < NUM_READ; i++) begin : g_read
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   port_data;
    logic              port_busy;

    assign addr = rs_address[i*ADDR_W +: ADDR_W];

    always_comb begin
      port_data = '0;
      port_busy = 1'b0;
      if (is_live_reg(32'(addr))) begin
        port_data = regs[addr];
        port_busy = busy_vector[addr];
`ifdef REGFILE_BYPASS_EN
        // Forward the in-flight writeback; busy only if a new producer issues this cycle.
        if (wr_en && addr == rd_address) begin
          port_data = write_data;
          port_busy = iss_en && (issue_rd == addr);
        end
`endif
      end
    end

    assign rs_data[i*XLEN +: XLEN] = port_data;
    assign rs_busy[i]              = port_busy;
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// tb/tb_multiport_register_file.sv - randomized and directed checks of multiport_register_file against a behavioural model
module tb_multiport_register_file;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic            clock = 1'b0;
  logic            reset;
  logic            reg_write;
  logic [AW-1:0]   rd_address;
  logic [XLEN-1:0] write_data;
  logic [NRD*AW-1:0]   rs_address;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]  rs_busy;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic [NREG-1:0] busy_vector;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [XLEN-1:0] m_regs [NREG];
  bit              m_busy [NREG];

  always #5 clock = ~clock;

  multiport_register_file dut (
    .clock       (clock),
    .reset       (reset),
    .reg_write   (reg_write),
    .rd_address  (rd_address),
    .write_data  (write_data),
    .rs_address  (rs_address),
    .rs_data     (rs_data),
    .rs_busy     (rs_busy),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .busy_vector (busy_vector)
  );

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Model state follows the architectural rules directly: reset clears, writeback then issue.
  always @(posedge clock) begin
    if (reset) begin
      for (int n = 0; n < NREG; n++) begin
        m_regs[n] = '0;
        m_busy[n] = 1'b0;
      end
    end else begin
      if (reg_write && rd_address != 0) begin
        m_regs[rd_address] = write_data;
        m_busy[rd_address] = 1'b0;
      end
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    end
  end

  function automatic logic [XLEN-1:0] exp_data(input int a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (!reset && reg_write && rd_address == a) return write_data;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (!reset && reg_write && rd_address == a) return !reset && issue_valid && issue_rd == a;
`endif
    return m_busy[a];
  endfunction

  always @(negedge clock) begin
    if (chk_en) begin
      logic [NREG-1:0] bv;
      for (int n = 0; n < NREG; n++) bv[n] = m_busy[n];
      for (int p = 0; p < NRD; p++) begin
        int a;
        a = int'(rs_address[p*AW +: AW]);
        check($sformatf("rs_data%0d", p), rs_data[p*XLEN +: XLEN], exp_data(a));
        check($sformatf("rs_busy%0d", p), 64'(rs_busy[p]), 64'(exp_busy(a)));
      end
      check("busy_vector", 64'(busy_vector), 64'(bv));
    end
  end

  task automatic set_in(input bit rst, input bit rw, input int rd, input logic [XLEN-1:0] wd,
                        input bit iv, input int ird, input int a0, input int a1);
    reset       = rst;
    reg_write   = rw;
    rd_address  = AW'(rd);
    write_data  = wd;
    issue_valid = iv;
    issue_rd    = AW'(ird);
    rs_address  = {AW'(a1), AW'(a0)};
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    for (int n = 0; n < NREG; n++) begin
      m_regs[n] = '0;
      m_busy[n] = 1'b0;
    end
    set_in(1, 0, 0, '0, 0, 0, 0, 0);
    tick();
    chk_en = 1'b1;

    // Preload then reset
    set_in(0, 1, 12, 64'h1234, 1, 13, 12, 13);
    tick();
    set_in(1, 0, 0, '0, 0, 0, 12, 13);
    tick();
    set_in(0, 0, 0, '0, 0, 0, 12, 13);
    settle();
    check("reset_x12", rs_data[63:0], 64'h0);
    check("reset_bv", 64'(busy_vector), 64'h0);

    set_in(0, 1, 5, 64'hDEAD_BEEF_0000_0001, 0, 0, 0, 0);
    tick();
    set_in(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 5, 5);
    settle();
    check("x5_p0", rs_data[63:0], 64'hDEAD_BEEF_0000_0001);
    check("x5_p1", rs_data[127:64], 64'hDEAD_BEEF_0000_0001);
    check("model_x5", m_regs[5], 64'hDEAD_BEEF_0000_0001);
    tick();
    set_in(0, 0, 0, '0, 0, 0, 0, 5);
    settle();
    check("x0_zero", rs_data[63:0], 64'h0);

    set_in(0, 0, 0, '0, 1, 7, 7, 0);
    tick();
    set_in(0, 0, 0, '0, 0, 0, 7, 0);
    settle();
    check("x7_busy_c1", 64'(rs_busy[0]), 64'h1);
    tick();
    settle();
    check("x7_busy_c2", 64'(rs_busy[0]), 64'h1);
    set_in(0, 1, 7, 64'h42, 0, 0, 7, 0);
    settle();
`ifdef REGFILE_BYPASS_EN
    check("x7_busy_wb", 64'(rs_busy[0]), 64'h0);
`else
    check("x7_busy_wb", 64'(rs_busy[0]), 64'h1);
`endif
    tick();
    set_in(0, 0, 0, '0, 0, 0, 7, 0);
    settle();
    check("x7_busy_after", 64'(rs_busy[0]), 64'h0);
    check("x7_data", rs_data[63:0], 64'h42);

    set_in(0, 1, 9, 64'h10, 1, 9, 0, 0);
    tick();
    set_in(0, 0, 0, '0, 0, 0, 9, 0);
    settle();
    check("x9_busy", 64'(busy_vector[9]), 64'h1);
    check("x9_data", rs_data[63:0], 64'h10);
    check("model_x9_busy", 64'(m_busy[9]), 64'h1);

    set_in(0, 1, 3, 64'h11, 0, 0, 0, 0);
    tick();
    set_in(0, 1, 3, 64'h77, 0, 0, 3, 0);
    settle();
`ifdef REGFILE_BYPASS_EN
    check("x3_bypass", rs_data[63:0], 64'h77);
`else
    check("x3_nobypass", rs_data[63:0], 64'h11);
`endif
    check("x3_busy", 64'(rs_busy[0]), 64'h0);
    tick();

    set_in(0, 0, 0, '0, 1, 4, 0, 0);
    tick();
    set_in(1, 1, 4, 64'h99, 0, 0, 4, 0);
    tick();
    set_in(0, 0, 0, '0, 0, 0, 4, 0);
    settle();
    check("x4_rst_data", rs_data[63:0], 64'h0);
    check("x4_rst_busy", 64'(busy_vector[4]), 64'h0);

    // Randomized traffic; small address range so collisions are frequent.
    for (int c = 0; c < 3000; c++) begin
      int rd, ird, a0, a1, lim;
      lim = ($urandom_range(0, 3) == 0) ? 31 : 7;
      rd  = $urandom_range(0, lim);
      ird = ($urandom_range(0, 3) == 0) ? rd : $urandom_range(0, lim);
      a0  = ($urandom_range(0, 1) == 0) ? rd : $urandom_range(0, lim);
      a1  = ($urandom_range(0, 2) == 0) ? ird : $urandom_range(0, lim);
      set_in($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, rd,
             {$urandom, $urandom}, $urandom_range(0, 4) < 2, ird, a0, a1);
      tick();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
